// File: rtl/mem_read_arbiter.sv
// ---------------------------------------------------------------------------
// mem_read_arbiter
//
// Purpose:
//   Two-requester read arbiter and sequencer sitting in front of a 256x16
//   ROM-style memory. Requesters issue byte-addressed reads over valid/ready.
//   The block picks one requester, drives the memory word address, chip
//   select and byte select with the timing the memory needs, and returns the
//   selected byte to the owning requester as a single-cycle response pulse.
//
//   The memory registers its read data internally, so a read is a two-cycle
//   affair: one cycle to present the address (RD) and one cycle where the
//   byte mux output is valid (DATA). The response cycle overlaps with IDLE,
//   which lets a new request be accepted while the previous response is
//   being delivered. Accept to response is 3 cycles; sustained throughput is
//   one read every 3 cycles.
//
// Configuration macro:
//   MEM_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins a tie.
//                           When undefined (default), ties are resolved
//                           round-robin using the last granted requester.
//
// Ports:
//   clk            - system clock, rising edge active
//   reset          - synchronous, active-high reset
//   req0_valid     - requester 0 has a read request
//   req0_ready     - requester 0 request accepted this cycle (with valid)
//   req0_addr      - requester 0 byte address: [WORD_AW:1] word, [0] byte
//   rsp0_valid     - one-cycle pulse, rsp0_data is valid
//   rsp0_data      - read byte for requester 0, held until next response
//   req1_*/rsp1_*  - same as above, for requester 1
//   mem_addr       - word address to the memory
//   mem_cs         - memory chip select / read enable
//   mem_byte_sel   - memory byte select (1 = high byte)
//   mem_data_byte  - byte output of the memory (only driven while mem_cs=1)
//   busy           - high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module mem_read_arbiter #(
    parameter int WORD_AW = 8,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WORD_AW:0]   req0_addr,
    output logic               rsp0_valid,
    output logic [DATA_W-1:0]  rsp0_data,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WORD_AW:0]   req1_addr,
    output logic               rsp1_valid,
    output logic [DATA_W-1:0]  rsp1_data,

    output logic [WORD_AW-1:0] mem_addr,
    output logic               mem_cs,
    output logic               mem_byte_sel,
    input  logic [DATA_W-1:0]  mem_data_byte,

    output logic               busy
);

    // The response pulse is issued in the cycle after DATA, which is already
    // IDLE again; that is what allows back-to-back accepts every 3 cycles.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state_q;
    logic                owner_q;
    logic                last_grant_q;
    logic [WORD_AW-1:0]  mem_addr_q;
    logic                mem_byte_sel_q;
    logic                mem_cs_q;
    logic                rsp0_valid_q;
    logic                rsp1_valid_q;
    logic [DATA_W-1:0]   rsp0_data_q;
    logic [DATA_W-1:0]   rsp1_data_q;

    logic                grant0;
    logic                grant1;
    logic                accept0;
    logic                accept1;
    logic                accept_any;
    logic [WORD_AW:0]    sel_addr;

    // Grant is purely combinational and only ever raised in IDLE, so the two
    // ready outputs are mutually exclusive and low while a read is in flight.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && !req1_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid && !req0_valid) begin
                grant1 = 1'b1;
            end else if (req0_valid && req1_valid) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                grant0 = 1'b1;
`else
                // Tie: hand the grant to whoever did not win last time.
                if (last_grant_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
`endif
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign accept0    = req0_valid && grant0;
    assign accept1    = req1_valid && grant1;
    assign accept_any = accept0 || accept1;
    assign sel_addr   = accept1 ? req1_addr : req0_addr;

    // Single sequencer register block. Every memory-facing and response
    // output comes straight from a flop so the memory sees glitch-free
    // controls and requesters see clean pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            owner_q        <= 1'b0;
            last_grant_q   <= 1'b1;
            mem_addr_q     <= '0;
            mem_byte_sel_q <= 1'b0;
            mem_cs_q       <= 1'b0;
            rsp0_valid_q   <= 1'b0;
            rsp1_valid_q   <= 1'b0;
            rsp0_data_q    <= '0;
            rsp1_data_q    <= '0;
        end else begin
            // Response valids are pulses unless DATA re-asserts them below.
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (accept_any) begin
                        mem_addr_q     <= sel_addr[WORD_AW:1];
                        mem_byte_sel_q <= sel_addr[0];
                        owner_q        <= accept1;
                        last_grant_q   <= accept1;
                        mem_cs_q       <= 1'b1;
                        state_q        <= RD;
                    end
                end

                RD: begin
                    // Memory captures the word at the end of this cycle;
                    // address, byte select and chip select stay put.
                    state_q <= DATA;
                end

                DATA: begin
                    // mem_cs is still high here, so the byte mux is driving
                    // and this is the only place the memory output is read.
                    if (owner_q) begin
                        rsp1_data_q  <= mem_data_byte;
                        rsp1_valid_q <= 1'b1;
                    end else begin
                        rsp0_data_q  <= mem_data_byte;
                        rsp0_valid_q <= 1'b1;
                    end
                    mem_cs_q <= 1'b0;
                    state_q  <= IDLE;
                end

                default: begin
                    mem_cs_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_byte_sel = mem_byte_sel_q;
    assign mem_cs       = mem_cs_q;
    assign rsp0_valid   = rsp0_valid_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign rsp0_data    = rsp0_data_q;
    assign rsp1_data    = rsp1_data_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_read_arbiter
//
// Self-checking bench for mem_read_arbiter. Contains a behavioural model of
// the 256x16 memory (registered word read, byte mux driving only while cs is
// high). Expected response bytes are computed from the bench's own memory
// contents and queued when a request is driven; they are popped and compared
// when the arbiter pulses a response.
// Honours MEM_ARB_FIXED_PRIO_EN for the tie-break expectation.
// ---------------------------------------------------------------------------
module tb_mem_read_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid;
    logic       req0_ready;
    logic [8:0] req0_addr;
    logic       rsp0_valid;
    logic [7:0] rsp0_data;
    logic       req1_valid;
    logic       req1_ready;
    logic [8:0] req1_addr;
    logic       rsp1_valid;
    logic [7:0] rsp1_data;
    logic [7:0] mem_addr;
    logic       mem_cs;
    logic       mem_byte_sel;
    logic       busy;

    logic [15:0] mem [256];
    logic [15:0] wordQ;

    typedef struct packed {
        logic       r;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory model: word registered on a clock edge while selected, byte
    // mux only drives while cs is high.
    always @(posedge clk) begin
        if (mem_cs) wordQ <= mem[mem_addr];
    end

    wire [7:0] mem_data_byte = mem_cs ? (mem_byte_sel ? wordQ[15:8] : wordQ[7:0]) : 8'bz;

    mem_read_arbiter #(.WORD_AW(8), .DATA_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_addr     (req0_addr),
        .rsp0_valid    (rsp0_valid),
        .rsp0_data     (rsp0_data),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_addr     (req1_addr),
        .rsp1_valid    (rsp1_valid),
        .rsp1_data     (rsp1_data),
        .mem_addr      (mem_addr),
        .mem_cs        (mem_cs),
        .mem_byte_sel  (mem_byte_sel),
        .mem_data_byte (mem_data_byte),
        .busy          (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] modelByte(input logic [8:0] a);
        logic [15:0] w;
        w = mem[a[8:1]];
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    task automatic pushExp(input logic r, input logic [8:0] a);
        exp_t e;
        e.r = r;
        e.d = modelByte(a);
        sb.push_back(e);
    endtask

    // Called in the cycle where requester r should be pulsing its response.
    task automatic checkRsp(input logic r);
        exp_t e;
        checkOutput(r ? "rsp1_valid" : "rsp0_valid", 16'(r ? rsp1_valid : rsp0_valid), 16'd1);
        checkOutput(r ? "rsp0_quiet" : "rsp1_quiet", 16'(r ? rsp0_valid : rsp1_valid), 16'd0);
        checkOutput("sb_nonempty", 16'(sb.size() != 0), 16'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput("rsp_owner", 16'(r), 16'(e.r));
            checkOutput(r ? "rsp1_data" : "rsp0_data", 16'(r ? rsp1_data : rsp0_data), 16'(e.d));
        end
    endtask

    // One isolated read from requester r at byte address a, checking the
    // full cycle-by-cycle memory handshake and the response.
    task automatic applyStimulus(input logic r, input logic [8:0] a);
        logic [7:0] keep0;
        logic [7:0] keep1;
        keep0 = rsp0_data;
        keep1 = rsp1_data;
        req0_valid = !r;
        req1_valid = r;
        if (r) req1_addr = a;
        else   req0_addr = a;
        #1;
        checkOutput("ready_win",  16'(r ? req1_ready : req0_ready), 16'd1);
        checkOutput("ready_lose", 16'(r ? req0_ready : req1_ready), 16'd0);
        pushExp(r, a);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("rd_cs",      16'(mem_cs), 16'd1);
        checkOutput("rd_busy",    16'(busy), 16'd1);
        checkOutput("rd_addr",    16'(mem_addr), 16'(a[8:1]));
        checkOutput("rd_bytesel", 16'(mem_byte_sel), 16'(a[0]));
        tick();
        checkOutput("data_cs",    16'(mem_cs), 16'd1);
        checkOutput("data_busy",  16'(busy), 16'd1);
        tick();
        checkRsp(r);
        checkOutput("rsp_cs",     16'(mem_cs), 16'd0);
        checkOutput("rsp_busy",   16'(busy), 16'd0);
        checkOutput("other_data", 16'(r ? rsp0_data : rsp1_data), 16'(r ? keep0 : keep1));
        tick();
        checkOutput("pulse_end",  16'(r ? rsp1_valid : rsp0_valid), 16'd0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       g;
        logic [7:0] d0;
        logic [7:0] d1;

        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'h00] = 16'hBEEF;
        mem[8'hFF] = 16'h1234;
        req0_addr = '0;
        req1_addr = '0;
        doReset();

        // Reset state
        #1;
        checkOutput("rst_cs",     16'(mem_cs), 16'd0);
        checkOutput("rst_addr",   16'(mem_addr), 16'd0);
        checkOutput("rst_bsel",   16'(mem_byte_sel), 16'd0);
        checkOutput("rst_rsp0v",  16'(rsp0_valid), 16'd0);
        checkOutput("rst_rsp1v",  16'(rsp1_valid), 16'd0);
        checkOutput("rst_rsp0d",  16'(rsp0_data), 16'd0);
        checkOutput("rst_rsp1d",  16'(rsp1_data), 16'd0);
        checkOutput("rst_busy",   16'(busy), 16'd0);
        checkOutput("rst_ready0", 16'(req0_ready), 16'd0);
        checkOutput("rst_ready1", 16'(req1_ready), 16'd0);

        // Byte selection within word 0 and the top word 0xFF
        applyStimulus(1'b0, 9'h000);
        checkOutput("beef_lo", 16'(rsp0_data), 16'h00EF);
        applyStimulus(1'b0, 9'h001);
        checkOutput("beef_hi", 16'(rsp0_data), 16'h00BE);
        applyStimulus(1'b1, 9'h1FF);
        checkOutput("top_hi", 16'(rsp1_data), 16'h0012);
        applyStimulus(1'b1, 9'h1FE);
        checkOutput("top_lo", 16'(rsp1_data), 16'h0034);
        checkOutput("rsp0_untouched", 16'(rsp0_data), 16'h00BE);

        // Assorted single reads from both requesters
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'(i % 2), 9'($urandom_range(0, 511)));
        end

        // Both requesters valid continuously from reset
        doReset();
        req0_addr  = 9'h010;
        req1_addr  = 9'h021;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            g = 1'b0;
`else
            g = 1'(i % 2);
`endif
            checkOutput("tie_ready0", 16'(req0_ready), 16'(!g));
            checkOutput("tie_ready1", 16'(req1_ready), 16'(g));
            pushExp(g, g ? req1_addr : req0_addr);
            tick();
            tick();
            tick();
            checkRsp(g);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        checkOutput("tie_drain_busy", 16'(busy), 16'd0);

        // Requester 1 arrives while requester 0 is in DATA
        req0_addr  = 9'h002;
        req0_valid = 1'b1;
        #1;
        checkOutput("hold_r0_ready", 16'(req0_ready), 16'd1);
        pushExp(1'b0, 9'h002);
        tick();
        req0_valid = 1'b0;
        tick();
        req1_addr  = 9'h0FE;
        req1_valid = 1'b1;
        #1;
        checkOutput("hold_r1_blocked", 16'(req1_ready), 16'd0);
        checkOutput("hold_busy", 16'(busy), 16'd1);
        tick();
        checkRsp(1'b0);
        checkOutput("hold_r1_ready", 16'(req1_ready), 16'd1);
        pushExp(1'b1, 9'h0FE);
        tick();
        req1_valid = 1'b0;
        checkOutput("hold_r1_cs", 16'(mem_cs), 16'd1);
        tick();
        tick();
        checkRsp(1'b1);

        // Reset while a read is in DATA: the read must vanish
        req0_addr  = 9'h003;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        checkOutput("mid_in_data", 16'(mem_cs), 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_cs",    16'(mem_cs), 16'd0);
        checkOutput("mid_busy",  16'(busy), 16'd0);
        checkOutput("mid_rsp0d", 16'(rsp0_data), 16'd0);
        checkOutput("mid_rsp1d", 16'(rsp1_data), 16'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("mid_rsp0v", 16'(rsp0_valid), 16'd0);
            checkOutput("mid_rsp1v", 16'(rsp1_valid), 16'd0);
            tick();
        end

        // Idle hold after a response
        applyStimulus(1'b1, 9'h1FF);
        applyStimulus(1'b0, 9'h001);
        d0 = rsp0_data;
        d1 = rsp1_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("idle_rsp0d", 16'(rsp0_data), 16'(d0));
            checkOutput("idle_rsp1d", 16'(rsp1_data), 16'(d1));
            checkOutput("idle_cs",    16'(mem_cs), 16'd0);
            checkOutput("idle_busy",  16'(busy), 16'd0);
            checkOutput("idle_rspv",  16'(rsp0_valid | rsp1_valid), 16'd0);
        end

        checkOutput("sb_drained", 16'(sb.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Two-requester read arbiter and sequencer in front of the 256x16 ROM-style memory block.
- The memory exposes an 8-bit word address, a chip select, a byte select and an 8-bit data output. Its read data is registered inside the RAM, and its byte-select mux only drives while cs is high.
- This block accepts byte-addressed read requests over valid/ready and arbitrates between requesters. It drives cs/addr/byte_sel with correct timing and returns one byte per request as a single-cycle response pulse.

Parameters:
- WORD_AW, 8, memory word address width; the request address is WORD_AW+1 bits (word address plus byte select).
- DATA_W, 8, byte width returned by the memory and to the requesters.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a read request.
- req0_ready  output  1  requester 0 request accepted this cycle when high with req0_valid.
- req0_addr  input  WORD_AW+1  requester 0 byte address; [WORD_AW:1] = word, [0] = byte (1 = high byte).
- rsp0_valid  output  1  one-cycle pulse: rsp0_data is valid.
- rsp0_data  output  DATA_W  read byte for requester 0.
- req1_valid, req1_ready, req1_addr, rsp1_valid, rsp1_data: same as requester 0, for requester 1.
- mem_addr  output  WORD_AW  word address to memory.
- mem_cs  output  1  memory chip select / read enable.
- mem_byte_sel  output  1  memory byte select.
- mem_data_byte  input  DATA_W  memory byte output (Z when mem_cs low).
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values: state=IDLE, mem_cs=0, mem_addr=0, mem_byte_sel=0, rsp0/1_valid=0, rsp0/1_data=0. Round-robin pointer last_grant=1, so requester 0 wins the first tie.
- States:
  - IDLE.
  - RD: mem_cs=1, address presented; the RAM captures on the closing edge.
  - DATA: mem_cs=1, addr and byte_sel held stable; mem_data_byte valid.
  - RSP: rsp pulse.
- IDLE: grant is computed combinationally from valid inputs.
  - Only one valid: that requester is granted.
  - Both valid: the requester other than last_grant is granted.
  - reqN_ready = (state==IDLE) && grant==N. Ready is never high for both requesters, and never high outside IDLE.
- Accept (valid && ready) in cycle T: register mem_addr=addr[WORD_AW:1], mem_byte_sel=addr[0], owner=N, last_grant=N. Go to RD.
- T+1 RD: mem_cs=1. Go to DATA.
- T+2 DATA: mem_cs=1 held. mem_data_byte is sampled into rspN_data at the closing edge. Go to RSP.
- T+3 RSP: rspN_valid=1 for exactly one cycle. mem_cs=0. State returns to IDLE in the same cycle, so a new accept may occur at T+3.
- Latency: accept to rsp_valid = 3 cycles. Throughput: one read per 3 cycles.
- mem_cs is low in IDLE and RSP. mem_data_byte is never sampled while mem_cs=0.
- rspN_data holds its value until the next response to requester N. The other requester's rsp_data and rsp_valid are unaffected.
- No response backpressure: the requester must take the pulse.
- A requester whose valid is high while not granted is held off (ready=0). It must keep valid and addr stable; the block does not latch unaccepted requests.
- Valid dropping before accept: no effect; nothing is issued.
- Reset mid-operation (any state): return to reset values next cycle. The in-flight read is dropped and no rsp_valid is issued.
- Address wrap: 9-bit addresses 0x000..0x1FF map directly with no wrap logic. 0x1FF reads the high byte of word 0xFF.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined: requester 0 always wins when both are valid. last_grant is still updated but ignored for arbitration.
- Undefined (default): round-robin as above.

Test Plan:
- Memory word0=16'hBEEF. req0 addr 0x000 at T -> req0_ready=1 at T, mem_cs=1 at T+1..T+2, rsp0_valid at T+3 with rsp0_data=0xEF. Then addr 0x001 -> 0xBE.
- Word 0xFF=16'h1234. req1 addr 0x1FF -> rsp1_data=0x12 at accept+3; addr 0x1FE -> 0x34. rsp0 untouched.
- Both valid continuously from reset: grants alternate 0,1,0,1, accepts every 3 cycles. With MEM_ARB_FIXED_PRIO_EN: req0 granted every time; req1 starves.
- req1_valid asserted during req0 DATA state -> req1_ready=0 until IDLE. Accepted at req0's RSP cycle; rsp1 pulse 3 cycles later with correct byte.
- reset asserted in DATA state -> next cycle mem_cs=0, busy=0, rsp0_valid/rsp1_valid both stay 0, rsp data registers read 0.
- After a response, hold req valids low for 10 cycles -> rsp_data stable, mem_cs=0, busy=0 throughout.
